// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline slice: control-bundle bit map,
// ALU op classes and immediate source encodings.
package id_ex_stage_pkg;

   localparam int CTRL_W            = 16;
   localparam int CTRL_REGWRITE     = 15;
   localparam int CTRL_MEMTOREG     = 14;
   localparam int CTRL_JAL          = 13;
   localparam int CTRL_MEMREAD      = 12;
   localparam int CTRL_MEMWRITE     = 11;
   localparam int CTRL_ISBRANCH     = 10;
   localparam int CTRL_ALUSRC       = 9;
   localparam int CTRL_BRANCHTYPE   = 8;
   localparam int CTRL_JALR         = 7;
   localparam int CTRL_ALUOP_MSB    = 6;
   localparam int CTRL_ALUOP_LSB    = 4;
   localparam int CTRL_MEMSIZE_MSB  = 3;
   localparam int CTRL_MEMSIZE_LSB  = 2;
   localparam int CTRL_LOADSIZE_MSB = 1;
   localparam int CTRL_LOADSIZE_LSB = 0;

   typedef enum logic [2:0] {
      ALU_OP_R      = 3'b000,
      ALU_OP_I      = 3'b001,
      ALU_OP_S      = 3'b010,
      ALU_OP_JAL    = 3'b011,
      ALU_OP_LOAD   = 3'b100,
      ALU_OP_BRANCH = 3'b101,
      ALU_OP_U      = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_SRC_I = 3'b000,
      IMM_SRC_S = 3'b001,
      IMM_SRC_B = 3'b010,
      IMM_SRC_U = 3'b011,
      IMM_SRC_J = 3'b100
   } imm_src_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check between the instruction in ID and a
// load currently occupying EX.
module load_use_detect (
   input  logic       id_valid,
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       hz
);

   // x0 is hardwired zero, so a load targeting it can never feed a consumer
   assign hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold/flush/bubble handling and saturating
// stall and flush event counters.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [2:0]        id_funct3,
   input  logic [6:0]        id_funct7,
   input  logic              ex_hold,
   input  logic              ex_flush,
   output logic              stall_id,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic hz;

   load_use_detect u_load_use_detect (
      .id_valid    (id_valid),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .hz          (hz)
   );

   // a flush discards the ID instruction, so its hazard must not freeze fetch
   assign stall_id = (hz & ~ex_flush) | ex_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct3   <= '0;
         ex_funct7   <= '0;
         bubble_cnt  <= '0;
         flush_cnt   <= '0;
      end else if (ex_hold) begin
         ex_valid <= ex_valid;
      end else if (ex_flush || hz) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct3   <= '0;
         ex_funct7   <= '0;
         if (ex_flush) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
         end else begin
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end else begin
         ex_valid    <= id_valid;
         ex_ctrl     <= id_valid ? id_ctrl : '0;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct3   <= id_funct3;
         ex_funct7   <= id_funct7;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, load-use bubble, x0 load, flush vs
// hazard, hold, counter saturation (CNT_W = 2) and asynchronous reset.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 2;
   localparam logic [15:0] CTRL_R  = 16'h8000;
   localparam logic [15:0] CTRL_LW = 16'hD240;

   logic              clk;
   logic              rst_n;
   logic              id_valid;
   logic [15:0]       id_ctrl;
   logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic [2:0]        id_funct3;
   logic [6:0]        id_funct7;
   logic              ex_hold, ex_flush;
   logic              stall_id, ex_valid;
   logic [15:0]       ex_ctrl;
   logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]        ex_rs1, ex_rs2, ex_rd;
   logic [2:0]        ex_funct3;
   logic [6:0]        ex_funct7;
   logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct3(id_funct3), .id_funct7(id_funct7), .ex_hold(ex_hold),
      .ex_flush(ex_flush), .stall_id(stall_id), .ex_valid(ex_valid),
      .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_funct7(ex_funct7), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [15:0] c, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      id_valid    = v;
      id_ctrl     = c;
      id_pc       = pc;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rd       = rd;
      id_rs1_data = pc + 32'h100;
      id_rs2_data = pc + 32'h200;
      id_imm      = pc + 32'h4;
      id_funct3   = 3'd2;
      id_funct7   = 7'h20;
   endtask

   initial begin
      rst_n    = 1'b0;
      ex_hold  = 1'b0;
      ex_flush = 1'b0;
      set_id(1'b0, 16'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      #3;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_stall_id", 32'(stall_id), 32'd0);
      #9 rst_n = 1'b1;

      // plain load of an R-type instruction
      set_id(1'b1, CTRL_R, 32'h40, 5'd1, 5'd2, 5'd5);
      #1 chk("load_stall_id", 32'(stall_id), 32'd0);
      tick();
      chk("load_ex_valid", 32'(ex_valid), 32'd1);
      chk("load_ex_ctrl", 32'(ex_ctrl), 32'h8000);
      chk("load_ex_rd", 32'(ex_rd), 32'd5);
      chk("load_ex_pc", 32'(ex_pc), 32'h40);
      chk("load_ex_imm", ex_imm, 32'h44);

      // lw x7 then consumer reading x7 via rs2
      set_id(1'b1, CTRL_LW, 32'h44, 5'd2, 5'd0, 5'd7);
      tick();
      chk("lw_ex_ctrl", 32'(ex_ctrl), 32'hD240);
      set_id(1'b1, CTRL_R, 32'h48, 5'd3, 5'd7, 5'd8);
      #1 chk("lu_stall_id", 32'(stall_id), 32'd1);
      tick();
      chk("lu_bub_valid", 32'(ex_valid), 32'd0);
      chk("lu_bub_ctrl", 32'(ex_ctrl), 32'd0);
      chk("lu_bub_rd", 32'(ex_rd), 32'd0);
      chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
      chk("lu_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("lu_stall_clear", 32'(stall_id), 32'd0);
      tick();
      chk("lu_cons_valid", 32'(ex_valid), 32'd1);
      chk("lu_cons_rd", 32'(ex_rd), 32'd8);
      chk("lu_cons_pc", 32'(ex_pc), 32'h48);

      // load targeting x0 never stalls
      set_id(1'b1, CTRL_LW, 32'h4C, 5'd2, 5'd0, 5'd0);
      tick();
      set_id(1'b1, CTRL_R, 32'h50, 5'd0, 5'd0, 5'd9);
      #1 chk("x0_stall_id", 32'(stall_id), 32'd0);
      tick();
      chk("x0_ex_valid", 32'(ex_valid), 32'd1);
      chk("x0_ex_rd", 32'(ex_rd), 32'd9);
      chk("x0_bubble_cnt", 32'(bubble_cnt), 32'd1);

      // flush coincident with a load-use hazard
      set_id(1'b1, CTRL_LW, 32'h54, 5'd1, 5'd1, 5'd7);
      tick();
      set_id(1'b1, CTRL_R, 32'h58, 5'd7, 5'd1, 5'd12);
      ex_flush = 1'b1;
      #1 chk("fh_stall_id", 32'(stall_id), 32'd0);
      tick();
      ex_flush = 1'b0;
      chk("fh_ex_valid", 32'(ex_valid), 32'd0);
      chk("fh_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("fh_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("fh_bubble_cnt", 32'(bubble_cnt), 32'd1);

      // hold for three edges with flush pending
      set_id(1'b1, CTRL_R, 32'h60, 5'd1, 5'd2, 5'd10);
      tick();
      set_id(1'b1, CTRL_R, 32'h64, 5'd1, 5'd2, 5'd11);
      ex_hold  = 1'b1;
      ex_flush = 1'b1;
      #1 chk("hold_stall_id", 32'(stall_id), 32'd1);
      repeat (3) tick();
      chk("hold_ex_valid", 32'(ex_valid), 32'd1);
      chk("hold_ex_rd", 32'(ex_rd), 32'd10);
      chk("hold_ex_pc", 32'(ex_pc), 32'h60);
      chk("hold_flush_cnt", 32'(flush_cnt), 32'd1);
      ex_hold = 1'b0;
      tick();
      chk("rel_ex_valid", 32'(ex_valid), 32'd0);
      chk("rel_ex_rd", 32'(ex_rd), 32'd0);
      chk("rel_flush_cnt", 32'(flush_cnt), 32'd2);
      ex_flush = 1'b0;
      tick();
      chk("post_ex_valid", 32'(ex_valid), 32'd1);

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ex_valid", 32'(ex_valid), 32'd0);
      chk("arst_ex_pc", 32'(ex_pc), 32'd0);
      chk("arst_ex_rd", 32'(ex_rd), 32'd0);
      chk("arst_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("arst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("arst_bubble_cnt", 32'(bubble_cnt), 32'd0);
      #2 rst_n = 1'b1;

      // five flushes saturate a 2-bit counter at 3
      ex_flush = 1'b1;
      tick();
      chk("sat_flush_1", 32'(flush_cnt), 32'd1);
      repeat (4) tick();
      chk("sat_flush_5", 32'(flush_cnt), 32'd3);
      chk("sat_bubble_cnt", 32'(bubble_cnt), 32'd0);
      ex_flush = 1'b0;

      // id_valid low forces ex_ctrl to zero while other fields follow ID
      set_id(1'b0, CTRL_LW, 32'h70, 5'd1, 5'd2, 5'd7);
      tick();
      chk("inv_ex_valid", 32'(ex_valid), 32'd0);
      chk("inv_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("inv_ex_rd", 32'(ex_rd), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, data path width.
REQ-002 Parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  the decode stage holds a real instruction.
REQ-006 id_ctrl  input  16  decoded control bundle, MSB first: RegWriteEn, MemtoReg, JAL, MemReadEn, MemWriteEn, IsBranch, ALUSrc, BranchType, JALR, alu_op[2:0], MemSize[1:0], LoadSize[1:0].
REQ-007 id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  decode-stage PC, register file read data and generated immediate.
REQ-008 id_rs1, id_rs2, id_rd  input  5 each  source and destination register indices.
REQ-009 id_funct3 input 3, id_funct7 input 7  passed to the EX ALU control.
REQ-010 ex_hold  input  1  downstream stall; the EX register must not advance.
REQ-011 ex_flush  input  1  taken branch or jump resolved in EX; kill the instruction entering EX.
REQ-012 stall_id  output  1  freeze PC and IF/ID this cycle (load-use hazard).
REQ-013 ex_valid output 1, ex_ctrl output 16, ex_pc/ex_rs1_data/ex_rs2_data/ex_imm output XLEN, ex_rs1/ex_rs2/ex_rd output 5, ex_funct3 output 3, ex_funct7 output 7  registered EX-stage copies.
REQ-014 bubble_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-015 Load-use hazard (combinational): hz = id_valid & ex_valid & ex_ctrl.MemReadEn & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-016 stall_id = hz & ~ex_flush | ex_hold; a flush overrides the hazard stall because the ID instruction is discarded.
REQ-017 Each edge applies exactly one action, in priority order: HOLD (ex_hold = 1) > FLUSH (ex_flush = 1) > BUBBLE (hz = 1) > LOAD (default).
REQ-018 HOLD: all ex_* registers and both counters keep their values.
REQ-019 FLUSH: ex_valid <= 0; ex_ctrl <= 0; all other ex_* fields <= 0; flush_cnt increments.
REQ-020 BUBBLE: same register effect as FLUSH; bubble_cnt increments instead of flush_cnt.
REQ-021 LOAD: ex_valid <= id_valid; all ex_* fields <= the corresponding id_* values; if id_valid = 0, ex_ctrl <= 0.
REQ-022 Invariant: ex_valid = 0 implies ex_ctrl = 0, so RegWriteEn, MemReadEn, MemWriteEn, IsBranch, JAL and JALR are never asserted for a bubble.
REQ-023 Latency is one cycle from ID to EX; a load-use stall inserts exactly one bubble, and hz clears on the next edge because ex_valid becomes 0.
REQ-024 Counters saturate at 2^CNT_W - 1 and do not wrap; they count only on edges where their action is taken.
REQ-025 ex_flush asserted during ex_hold has no effect; the source must keep it asserted until hold releases.
REQ-026 An instruction with rd = x0 never triggers a hazard, even when MemReadEn = 1.

Reset
REQ-027 While rst_n = 0, all ex_* outputs, ex_valid, bubble_cnt and flush_cnt are 0, immediately and independent of clk.
REQ-028 stall_id = 0 during reset, since it is derived only from reset-cleared state and the inputs.
REQ-029 Deassertion mid-stream: the first edge with rst_n = 1 performs normal LOAD/BUBBLE/FLUSH/HOLD evaluation.

Structure
REQ-030 The shared package holds: the ctrl bundle bit positions (CTRL_REGWRITE = 15 ... CTRL_LOADSIZE_LSB = 0) and width (16), the alu_op encodings (R = 000, I = 001, S = 010, JAL = 011, LOAD = 100, BRANCH = 101, U = 111), and the ImmSrc encodings.
REQ-031 One sub-module, load_use_detect (purely combinational, implements REQ-015), is instantiated once; the pipeline register and counters live in id_ex_stage.

Verification
REQ-032 LOAD: id_valid = 1, id_ctrl = 16'h8000 (R-type), id_rd = 5, id_pc = 0x40 -> one edge later ex_valid = 1, ex_ctrl = 16'h8000, ex_rd = 5, ex_pc = 0x40; stall_id = 0.
REQ-033 Load-use: EX holds lw with rd = 7 (MemReadEn = 1); ID has id_rs2 = 7 -> stall_id = 1 that cycle; the next edge gives ex_valid = 0, ex_ctrl = 0 and bubble_cnt = 1; then stall_id = 0 and the consumer loads.
REQ-034 Load to x0: ex_rd = 0 with MemReadEn = 1, id_rs1 = 0 -> stall_id = 0, no bubble.
REQ-035 Flush + hazard in the same cycle -> stall_id = 0, bubble inserted, flush_cnt = 1, bubble_cnt unchanged.
REQ-036 ex_hold = 1 for 3 cycles with ex_flush = 1 -> ex_* unchanged and counters unchanged; after release with flush still high -> bubble and flush_cnt = 1.
REQ-037 Saturation and async reset: with CNT_W = 2, 5 flushes -> flush_cnt = 3; drop rst_n between edges -> all outputs 0 before the next clk edge.
